// File: rtl/fight_if.sv
// fight_if: start/pose/ko requests in, hit strobes and match status out.
// master drives start, state1, state2, ko; slave drives hit1, hit2, dmg, phase, round, sec_left.
interface fight_if;
  logic       start;
  logic [1:0] state1;
  logic [1:0] state2;
  logic       ko;
  logic       hit1;
  logic       hit2;
  logic [1:0] dmg;
  logic [2:0] phase;
  logic [1:0] round;
  logic [5:0] sec_left;

  modport master (
    output start, state1, state2, ko,
    input  hit1, hit2, dmg, phase, round, sec_left
  );

  modport slave (
    input  start, state1, state2, ko,
    output hit1, hit2, dmg, phase, round, sec_left
  );
endinterface

// File: rtl/fight_ctrl.sv
// fight_ctrl: round/phase sequencer with second timer and punch arbiter.
// Ports: clk, rst (async active-low), bus (fight_if.slave).
module fight_ctrl #(
  parameter int CLK_PER_SEC   = 50000000,
  parameter int COUNTDOWN_SEC = 3,
  parameter int ROUND_SEC     = 30,
  parameter int BREAK_SEC     = 10,
  parameter int NUM_ROUNDS    = 3,
  parameter int COOLDOWN      = 8
) (
  input logic    clk,
  input logic    rst,
  fight_if.slave bus
);
  localparam int PW =
    (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_PER_SEC - 1);
  localparam logic [1:0] NR  = 2'(NUM_ROUNDS);
  localparam logic [7:0] CDV = 8'(COOLDOWN);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    FIGHT = 3'd2,
    BREAK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        st, st_nx;
  logic [PW-1:0] presc;
  logic [5:0]    sec, sec_ld;
  logic [1:0]    rnd;
  logic [1:0]    p1q, p2q;
  logic [1:0]    dmg_q, dmg_nx;
  logic [7:0]    cd1, cd2;
  logic          prio;
  logic          hit1_q, hit2_q;
  logic          timed, tick, last, entry, fight_in;
  logic          e1, e2, g1, g2;

  function automatic logic [1:0] dmg_of(
    input logic [1:0] pose
  );
    unique case (pose)
      2'b00:   return 2'd2;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  assign timed = (st == COUNT) ||
                 (st == FIGHT) ||
                 (st == BREAK);
  assign tick  = timed && (presc == PMAX);
  assign last  = tick && (sec == 6'd1);

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE, DONE: if (bus.start) st_nx = COUNT;
      COUNT:      if (last) st_nx = FIGHT;
      FIGHT: begin
        if (bus.ko)
          st_nx = DONE;
        else if (last)
          st_nx = (rnd < NR) ? BREAK : DONE;
      end
      BREAK:      if (last) st_nx = COUNT;
      default:    st_nx = IDLE;
    endcase
  end

  assign entry    = (st_nx != st);
  assign fight_in = entry && (st_nx == FIGHT);

  always_comb begin
    sec_ld = '0;
    unique case (st_nx)
      COUNT:   sec_ld = 6'(COUNTDOWN_SEC);
      FIGHT:   sec_ld = 6'(ROUND_SEC);
      BREAK:   sec_ld = 6'(BREAK_SEC);
      default: sec_ld = '0;
    endcase
  end

  // Rising edge into punch, gated by phase, ko and cooldown.
  always_comb begin
    e1 = (st == FIGHT) && !bus.ko &&
         (cd1 == 8'd0) &&
         (bus.state1 == 2'b11) && (p1q != 2'b11);
    e2 = (st == FIGHT) && !bus.ko &&
         (cd2 == 8'd0) &&
         (bus.state2 == 2'b11) && (p2q != 2'b11);
    // prio=0 favours player 1 on a tie.
    g1 = e1 && !(e2 && prio);
    g2 = e2 && !(e1 && !prio);
    dmg_nx = 2'd0;
    if (g1)
      dmg_nx = dmg_of(bus.state2);
    else if (g2)
      dmg_nx = dmg_of(bus.state1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      st <= IDLE;
    else
      st <= st_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      sec   <= '0;
      rnd   <= 2'd1;
    end else if (entry) begin
      presc <= '0;
      sec   <= sec_ld;
      if (st_nx == COUNT)
        rnd <= (st == BREAK) ? rnd + 2'd1 : 2'd1;
    end else if (timed) begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick)
        sec <= sec - 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1q    <= 2'b00;
      p2q    <= 2'b00;
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
      dmg_q  <= 2'd0;
      prio   <= 1'b0;
      cd1    <= 8'd0;
      cd2    <= 8'd0;
    end else begin
      p1q    <= bus.state1;
      p2q    <= bus.state2;
      hit1_q <= g1;
      hit2_q <= g2;
      dmg_q  <= dmg_nx;
      if (e1 && e2)
        prio <= ~prio;
      if (fight_in)
        cd1 <= 8'd0;
      else if (g1)
        cd1 <= CDV;
      else if (cd1 != 8'd0)
        cd1 <= cd1 - 8'd1;
      if (fight_in)
        cd2 <= 8'd0;
      else if (g2)
        cd2 <= CDV;
      else if (cd2 != 8'd0)
        cd2 <= cd2 - 8'd1;
    end
  end

  assign bus.hit1     = hit1_q;
  assign bus.hit2     = hit2_q;
  assign bus.dmg      = dmg_q;
  assign bus.phase    = st;
  assign bus.round    = rnd;
  assign bus.sec_left = sec;
endmodule

// File: tb/tb_fight_ctrl.sv
// tb_fight_ctrl: scoreboard bench for fight_ctrl with a cycle-count model.
// Drives fight_if as master; monitor checks status and hit strobes.
module tb_fight_ctrl;
  localparam int CPS = 4;
  localparam int CDS = 3;
  localparam int RS  = 5;
  localparam int BS  = 2;
  localparam int NR  = 2;
  localparam int CDN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fight_if bus();

  fight_ctrl #(
    .CLK_PER_SEC(CPS),
    .COUNTDOWN_SEC(CDS),
    .ROUND_SEC(RS),
    .BREAK_SEC(BS),
    .NUM_ROUNDS(NR),
    .COOLDOWN(CDN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int cyc;
    int who;
    int dmg;
  } exp_t;
  exp_t q[$];

  // Model: phase, round, cycles left in phase.
  int m_phase = 0;
  int m_round = 1;
  int m_rem   = 0;
  int m_cd1   = 0;
  int m_cd2   = 0;
  int m_prio  = 0;
  int m_prev1 = 0;
  int m_prev2 = 0;

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d",
               name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout required event", name);
  endtask

  function automatic int dmg_of(input int pose);
    if (pose == 0) return 2;
    if (pose == 1) return 1;
    return 3;
  endfunction

  function automatic int m_sec();
    if (m_phase >= 1 && m_phase <= 3)
      return (m_rem + CPS - 1) / CPS;
    return 0;
  endfunction

  always @(posedge clk) begin : model
    int  s1, s2;
    bit  sr, k, e1, e2, g1, g2;
    exp_t e;
    cyc++;
    if (!rst) begin
      m_phase = 0; m_round = 1; m_rem = 0;
      m_cd1 = 0; m_cd2 = 0; m_prio = 0;
      m_prev1 = 0; m_prev2 = 0;
      q.delete();
    end else begin
      s1 = int'(bus.state1);
      s2 = int'(bus.state2);
      sr = bus.start;
      k  = bus.ko;
      e1 = (m_phase == 2) && !k && (m_cd1 == 0) &&
           (s1 == 3) && (m_prev1 != 3);
      e2 = (m_phase == 2) && !k && (m_cd2 == 0) &&
           (s2 == 3) && (m_prev2 != 3);
      if (e1 && e2) begin
        g1 = (m_prio == 0);
        g2 = !g1;
        m_prio = 1 - m_prio;
      end else begin
        g1 = e1;
        g2 = e2;
      end
      if (g1) begin
        e.cyc = cyc; e.who = 1; e.dmg = dmg_of(s2);
        q.push_back(e);
      end
      if (g2) begin
        e.cyc = cyc; e.who = 2; e.dmg = dmg_of(s1);
        q.push_back(e);
      end
      m_cd1 = g1 ? CDN : (m_cd1 > 0 ? m_cd1 - 1 : 0);
      m_cd2 = g2 ? CDN : (m_cd2 > 0 ? m_cd2 - 1 : 0);
      m_prev1 = s1;
      m_prev2 = s2;
      case (m_phase)
        0, 4: if (sr) begin
          m_phase = 1; m_round = 1; m_rem = CDS * CPS;
        end
        1: begin
          m_rem--;
          if (m_rem == 0) begin
            m_phase = 2; m_rem = RS * CPS;
            m_cd1 = 0; m_cd2 = 0;
          end
        end
        2: if (k) begin
          m_phase = 4; m_rem = 0;
        end else begin
          m_rem--;
          if (m_rem == 0) begin
            if (m_round < NR) begin
              m_phase = 3; m_rem = BS * CPS;
            end else begin
              m_phase = 4;
            end
          end
        end
        3: begin
          m_rem--;
          if (m_rem == 0) begin
            m_phase = 1; m_round++;
            m_rem = CDS * CPS;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    chk("phase", int'(bus.phase), m_phase);
    chk("round", int'(bus.round), m_round);
    chk("sec_left", int'(bus.sec_left), m_sec());
    chk("strobe_excl", int'(bus.hit1 && bus.hit2), 0);
    if (!bus.hit1 && !bus.hit2) begin
      chk("dmg_idle", int'(bus.dmg), 0);
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        tests++;
        fails++;
        $display("FAIL hit_missed: got none required who=%0d dmg=%0d",
                 e.who, e.dmg);
      end
    end else if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL hit_unexpected: got hit1=%0d hit2=%0d dmg=%0d required none",
               bus.hit1, bus.hit2, bus.dmg);
    end else begin
      e = q.pop_front();
      chk("hit_cycle", cyc, e.cyc);
      chk("hit_who", bus.hit1 ? 1 : 2, e.who);
      chk("hit_dmg", int'(bus.dmg), e.dmg);
    end
  end

  task automatic step(input int a, input int b,
                      input bit s, input bit k);
    bus.state1 = 2'(a);
    bus.state2 = 2'(b);
    bus.start  = s;
    bus.ko     = k;
    @(negedge clk);
  endtask

  task automatic rstep();
    step($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);
  endtask

  int cnt[8];
  int n;

  initial begin
    bus.start  = 1'b0;
    bus.state1 = 2'b00;
    bus.state2 = 2'b00;
    bus.ko     = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_round", int'(bus.round), 1);
    chk("rst_sec", int'(bus.sec_left), 0);
    chk("rst_hit1", int'(bus.hit1), 0);
    chk("rst_hit2", int'(bus.hit2), 0);
    chk("rst_dmg", int'(bus.dmg), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) rstep();
    chk("idle_hold", int'(bus.phase), 0);

    // Full timed match, no punches.
    step(0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    cnt[bus.phase]++;
    for (int i = 0; i < 79; i++) begin
      step(0, 0, 1'b0, 1'b0);
      cnt[bus.phase]++;
    end
    chk("count_cycles", cnt[1], 24);
    chk("fight_cycles", cnt[2], 40);
    chk("break_cycles", cnt[3], 8);
    chk("done_cycles", cnt[4], 8);

    // Restart from DONE; directed punches in round 1.
    step(0, 0, 1'b1, 1'b0);
    repeat (12) step(0, 0, 1'b0, 1'b0);
    chk("fight_entry", int'(bus.phase), 2);
    step(3, 1, 1'b0, 1'b0);
    repeat (3) step(0, 0, 1'b0, 1'b0);
    step(3, 0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    step(3, 0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    step(3, 0, 1'b0, 1'b0);
    repeat (3) step(0, 0, 1'b0, 1'b0);
    step(3, 3, 1'b0, 1'b0);
    repeat (3) step(0, 0, 1'b0, 1'b0);
    step(3, 3, 1'b0, 1'b0);

    // Random poses with rare ko.
    repeat (150)
      step($urandom_range(0, 3), $urandom_range(0, 3),
           1'b0, $urandom_range(0, 31) == 0);

    // KO on the final tick of round 1.
    n = 0;
    while (m_phase != 1 && n < 300) begin
      step(0, 0, 1'b1, 1'b0);
      n++;
    end
    if (n >= 300) bad("wait_count");
    n = 0;
    while (!(m_phase == 2 && m_round == 1 && m_rem == 1) &&
           n < 300) begin
      rstep();
      n++;
    end
    if (n >= 300) bad("wait_last_tick");
    step($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b1);
    chk("ko_done", int'(bus.phase), 4);
    repeat (4) begin
      step(0, 0, 1'b0, 1'b0);
      step(3, 3, 1'b0, 1'b0);
    end
    step(0, 0, 1'b1, 1'b0);
    chk("done_restart_phase", int'(bus.phase), 1);
    chk("done_restart_round", int'(bus.round), 1);

    // Reset during round-2 fight.
    n = 0;
    while (!(m_phase == 2 && m_round == 2) && n < 300) begin
      rstep();
      n++;
    end
    if (n >= 300) bad("wait_round2");
    repeat (3) rstep();
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_phase", int'(bus.phase), 0);
    chk("mid_rst_round", int'(bus.round), 1);
    chk("mid_rst_sec", int'(bus.sec_left), 0);
    chk("mid_rst_hit1", int'(bus.hit1), 0);
    chk("mid_rst_hit2", int'(bus.hit2), 0);
    chk("mid_rst_dmg", int'(bus.dmg), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) rstep();
    chk("post_rst_idle", int'(bus.phase), 0);
    step(0, 0, 1'b1, 1'b0);
    chk("post_rst_start", int'(bus.phase), 1);
    repeat (2) rstep();
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fight_ctrl.md
FIGHT_CTRL -- requirements
Module: fight_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- CLK_PER_SEC, 50000000, clock cycles per one-second tick
- COUNTDOWN_SEC, 3, pre-round countdown length in seconds
- ROUND_SEC, 30, fight length per round in seconds (max 63)
- BREAK_SEC, 10, rest length between rounds in seconds (max 63)
- NUM_ROUNDS, 3, rounds per match (1..3)
- COOLDOWN, 8, cycles a player is blocked after a granted punch (max 255)

REQ-002 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  match start request, level sampled on clk
- state1  in  2  player-1 pose: 00 open, 01 guard, 10 dodge-fail, 11 punch
- state2  in  2  player-2 pose, same encoding
- ko  in  1  knockout flag from the scoring block
- hit1  out  1  one-cycle strobe: player 1 lands a hit on player 2
- hit2  out  1  one-cycle strobe: player 2 lands a hit on player 1
- dmg  out  2  damage of the current strobe (1..3), 0 when no strobe
- phase  out  3  0 IDLE, 1 COUNT, 2 FIGHT, 3 BREAK, 4 DONE
- round  out  2  current round number, 1-based
- sec_left  out  6  seconds remaining in the current timed phase

Function
REQ-003 The FSM SHALL use states IDLE, COUNT, FIGHT, BREAK and DONE, and phase SHALL equal the state encoding.
REQ-004 The FSM SHALL make these transitions:
- IDLE with start=1 -> COUNT, round=1.
- DONE with start=1 -> COUNT, round=1.
- start SHALL be ignored in COUNT, FIGHT and BREAK.
REQ-005 Second tick:
- A prescaler SHALL count 0..CLK_PER_SEC-1 and assert tick when it wraps.
- The prescaler SHALL clear to 0 on every state entry.
REQ-006 Phase timer:
- On entry to COUNT, FIGHT or BREAK, sec_left SHALL load COUNTDOWN_SEC, ROUND_SEC or BREAK_SEC respectively.
- sec_left SHALL decrement on each tick.
- A tick while sec_left==1 SHALL end the phase.
- sec_left SHALL be 0 in IDLE and DONE.
REQ-007 Phase-end transitions:
- COUNT end -> FIGHT.
- FIGHT end -> BREAK if round<NUM_ROUNDS, else DONE.
- BREAK end -> COUNT with round incremented.
REQ-008 ko=1 in FIGHT SHALL move the FSM to DONE at the next edge, with priority over a same-cycle timer expiry.
REQ-009 The block SHALL register each stateN every cycle. A punch is detected at the edge where stateN is sampled 11 and the previous sample was not 11.
REQ-010 For a granted punch, hitN SHALL assert for exactly one cycle starting at the detecting edge (latency 0 cycles after the sampling edge).
REQ-011 dmg SHALL be registered at the same edge from the defender's pose sampled at that edge: 00 -> 2, 01 -> 1, 10 or 11 -> 3.
REQ-012 A punch SHALL be eligible only if all of these hold:
- phase is FIGHT
- ko=0
- that player's cooldown counter is 0
Ineligible punches SHALL be dropped, not queued.
REQ-013 After a granted punch, that player's cooldown counter SHALL load COOLDOWN and decrement once per cycle down to 0. Both counters SHALL clear on entry to FIGHT.
REQ-014 When both players have eligible punches at the same edge:
- Only the player holding priority SHALL be granted.
- The other punch SHALL be dropped, with no cooldown loaded for it.
- Priority SHALL then pass to the other player.
- Priority SHALL change only on such conflicts.
REQ-015 hit1 and hit2 SHALL never be high in the same cycle, and dmg SHALL be 0 whenever both are low.
REQ-016 A hit strobe and a FIGHT exit SHALL be allowed to occur at the same edge; the hit SHALL still be issued.

Reset
REQ-017 While rst=0, the block SHALL immediately (asynchronously) drive these values: phase=IDLE, round=1, sec_left=0, hit1=0, hit2=0, dmg=0, prescaler=0, both cooldown counters=0, priority=player 1, both pose registers=00.
REQ-018 Reset asserted mid-match SHALL abandon the match. After release, the block SHALL stay in IDLE until start=1.

Verification
The bench SHALL use CLK_PER_SEC=4, COUNTDOWN_SEC=3, ROUND_SEC=5, BREAK_SEC=2, NUM_ROUNDS=2 and COOLDOWN=3.
REQ-019 Full timed match, no punches:
- Stimulus: start pulse in IDLE.
- Response: COUNT for 12 cycles (sec_left 3,2,1), FIGHT for 20 cycles, BREAK for 8 cycles, round=2, COUNT for 12, FIGHT for 20, then DONE with sec_left=0.
REQ-020 Damage table:
- Stimulus: in FIGHT, state1 00->11 while state2=01, then state1 00->11 while state2=00 (after cooldown).
- Response: hit1 with dmg=1, later hit1 with dmg=2; hit2 stays 0.
REQ-021 Cooldown:
- Stimulus: player 1 punches, then re-punches (11->00->11) within 3 cycles.
- Response: second punch dropped; a re-punch after the counter reaches 0 is granted.
REQ-022 Simultaneous punches:
- Stimulus: both stateN go 00->11 at the same edge, twice, separated by cooldown.
- Response: first event gives hit1 only, second gives hit2 only; never both strobes high.
REQ-023 KO and lockout:
- Stimulus: ko=1 during FIGHT, same cycle as the final tick.
- Response: next phase is DONE, not BREAK; punches in DONE give no strobes; start in DONE -> COUNT with round=1.
REQ-024 Reset mid-match:
- Stimulus: rst=0 during FIGHT, round 2.
- Response: immediately phase=0, round=1, sec_left=0, strobes low; start is needed to restart.
